// File: rtl/ram_sync_pkg.sv
// ram_sync_pkg: shared state type, collision-policy codes and default sizes for ram_sync_param
package ram_sync_pkg;
  typedef enum logic {ST_CLEAR, ST_RUN} state_t;
  localparam int RDW_READ_FIRST = 0;
  localparam int RDW_WRITE_FIRST = 1;
  localparam int DEF_DW = 8;
  localparam int DEF_AW = 8;
endpackage

// File: rtl/ram_sync_core.sv
// ram_sync_core: bare array with one write port and a registered read port
module ram_sync_core
  import ram_sync_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW,
  parameter int DEPTH = 2**AW,
  parameter int RDW_MODE = RDW_READ_FIRST
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic          re,
  input  logic          ok,
  input  logic [AW-1:0] ra,
  output logic [DW-1:0] q
);
  logic [DW-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[wa] <= wd;
  // read-first falls out of the non-blocking array read; write-first bypasses wd
  always_ff @(posedge clk)
    if (!rst_n) q <= '0;
    else if (re) q <= !ok ? '0 : (RDW_MODE == RDW_WRITE_FIRST && we && wa == ra) ? wd : mem[ra];
endmodule

// File: rtl/ram_sync_param.sv
// ram_sync_param: parametrised sync RAM with post-reset clear sweep, rd_valid and RDW policy
// Optional extra output register stage (latency 2) when RAM_SYNC_OUTREG_EN is defined.
module ram_sync_param
  import ram_sync_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW,
  parameter int DEPTH = 2**AW,
  parameter int RDW_MODE = RDW_READ_FIRST,
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic          busy
);
  localparam logic [AW:0] LIM = (AW+1)'(DEPTH);
  localparam logic [AW:0] LAST = (AW+1)'(DEPTH-1);
  state_t state, state_nx;
  logic [AW:0] cnt;
  logic clr, run, wr_ok, rd_ok, we, re, v1;
  logic [AW-1:0] wa;
  logic [DW-1:0] wd, d1;
  always_comb begin
    clr = rst_n && state == ST_CLEAR;
    run = rst_n && state == ST_RUN;
    wr_ok = {1'b0, wr_addr} < LIM;
    rd_ok = {1'b0, rd_addr} < LIM;
    we = clr || (run && wr_en && wr_ok);
    wa = clr ? cnt[AW-1:0] : wr_addr;
    wd = clr ? '0 : wr_data;
    re = run && rd_en;
    state_nx = (state == ST_CLEAR && cnt == LAST) ? ST_RUN : state;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= INIT_CLEAR ? ST_CLEAR : ST_RUN;
      cnt <= '0;
      v1 <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= clr ? cnt + 1'b1 : cnt;
      v1 <= re;
    end
  assign busy = state == ST_CLEAR;
  ram_sync_core #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .RDW_MODE(RDW_MODE)) u_core (
    .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd),
    .re(re), .ok(rd_ok), .ra(rd_addr), .q(d1)
  );
`ifdef RAM_SYNC_OUTREG_EN
  logic [DW-1:0] d2;
  logic v2;
  always_ff @(posedge clk)
    if (!rst_n) begin
      d2 <= '0;
      v2 <= 1'b0;
    end else begin
      v2 <= v1;
      if (v1) d2 <= d1;
    end
  assign rd_data = d2;
  assign rd_valid = v2;
`else
  assign rd_data = d1;
  assign rd_valid = v1;
`endif
endmodule
